pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter: DATA_W, default 32, payload width in bits (1..256).
REQ-002 Parameter: RESET_VAL, default all-zeros, DATA_W-bit value loaded into the output data register on reset and on flush.
REQ-003 Port: cpu_clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: cpu_rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: flush  in  1  synchronous kill of all held entries.
REQ-006 Port: in_valid  in  1  upstream presents a payload.
REQ-007 Port: in_data  in  DATA_W  upstream payload.
REQ-008 Port: in_ready  out  1  stage can accept; driven directly from a flop.
REQ-009 Port: out_valid  out  1  out_data holds a live payload.
REQ-010 Port: out_data  out  DATA_W  payload to downstream; driven directly from a flop.
REQ-011 Port: out_ready  in  1  downstream accepts this cycle.
REQ-012 Port: count  out  2  entries held, 0..2.

Function
REQ-013 The block SHALL hold two entries: a main register (drives out_*) and a skid register (skid_valid, skid_data).
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer with out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL equal NOT skid_valid, registered; no combinational path from out_ready to in_ready.
REQ-016 Main SHALL load when out_valid=0 or out_ready=1: from skid if skid_valid=1, else from in_data if an input transfer occurs; otherwise out_valid SHALL go 0 next cycle.
REQ-017 Main loaded from skid SHALL clear skid_valid the same edge; no input is accepted that edge (in_ready=0).
REQ-018 An input transfer while main is held (out_valid=1, out_ready=0) SHALL be written to skid, setting skid_valid=1.
REQ-019 Latency: a payload accepted into an empty block SHALL appear on out_data with out_valid=1 on the next edge (1 cycle).
REQ-020 With out_ready held 1 and in_valid held 1, throughput SHALL be one payload per cycle and skid SHALL stay empty.
REQ-021 Order SHALL be preserved; no payload is duplicated or dropped absent flush.
REQ-022 out_data and out_valid SHALL not change while out_valid=1 and out_ready=0, except on flush or reset.
REQ-023 flush=1 SHALL, next edge, clear out_valid and skid_valid, set out_data to RESET_VAL, set in_ready=1; it overrides any same-cycle input or output transfer (input payload discarded).
REQ-024 count SHALL equal out_valid + skid_valid, registered alongside them.
REQ-025 skid_data content when skid_valid=0 is don't-care and SHALL never reach out_data.
REQ-026 Full (count=2): in_ready=0; in_valid ignored; out_ready=1 moves skid to main, count=1, in_ready=1 next cycle.

Reset
REQ-027 While cpu_rst=1, asynchronously: out_valid=0, skid_valid=0, count=0, in_ready=1, out_data=RESET_VAL.
REQ-028 Reset mid-operation SHALL discard all held payloads; first edge after deassertion behaves as empty block.
REQ-029 No output SHALL be X after reset regardless of in_* values.

Verification
REQ-030 Stream: reset, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, count<=1, in_ready=1 throughout.
REQ-031 Backpressure: accept A=0x11, then out_ready=0, send B=0x22 -> count=2, in_ready=0, out_data=0x11 held; C=0x33 offered is not accepted.
REQ-032 Drain: from REQ-031 state, out_ready=1 for 3 cycles while C remains offered -> out_data 0x11, 0x22, 0x33 in order; in_ready returns 1 one cycle after first drain.
REQ-033 Flush: count=2, flush=1 with in_valid=1 data 0x44 -> next cycle count=0, out_valid=0, out_data=RESET_VAL, in_ready=1; 0x44 never appears.
REQ-034 Async reset: assert cpu_rst between edges with count=2 -> outputs reach REQ-027 values without a clock edge.
REQ-035 Random: random in_valid/out_ready/flush, DATA_W=8 and 64 -> scoreboard matches order and count; no output change under stall.

Source files
------------

// File: rtl/pipe_skid_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data, downstream
// valid/ready/data, flush and occupancy count.
interface pipe_skid_if #(
  parameter int unsigned DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [1:0]        count;

  // master is the surrounding pipeline, slave is the skid register itself
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register: every output comes straight from
// a flop, giving one-cycle latency and full throughput without a ready path.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic       cpu_clk,
  input  logic       cpu_rst,
  pipe_skid_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [DATA_W-1:0] skid_data_q;
  logic              in_fire;
  logic              main_load;
  logic              main_from_skid;
  logic              skid_load;

  assign in_fire = bus.in_valid & in_ready_q;

  // Occupancy FSM: ST_ONE holds a payload in main, ST_FULL also fills skid.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (bus.out_ready) begin
            if (in_fire) begin
              main_load = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they leave flops.
  always_comb begin
    in_ready_d  = 1'b1;
    out_valid_d = 1'b0;
    count_d     = 2'd0;
    case (state_d)
      ST_ONE: begin
        out_valid_d = 1'b1;
        count_d     = 2'd1;
      end
      ST_FULL: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        count_d     = 2'd2;
      end
      default: begin
        in_ready_d = 1'b1;
      end
    endcase

    main_data_d = main_data_q;
    if (bus.flush) begin
      main_data_d = RESET_VAL;
    end else if (main_load) begin
      main_data_d = main_from_skid ? skid_data_q : bus.in_data;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
      main_data_q <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      main_data_q <= main_data_d;
    end
  end

  // Skid data is only read in ST_FULL, so it carries no reset.
  always_ff @(posedge cpu_clk) begin
    if (skid_load) begin
      skid_data_q <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.count     = count_q;

  a_ready_tracks_skid: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    in_ready_q == (state_q != ST_FULL));

  a_count_consistent: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    count_q == ({1'b0, out_valid_q} + {1'b0, state_q == ST_FULL}));

  a_stall_hold: assert property (@(posedge cpu_clk) disable iff (cpu_rst)
    (out_valid_q && !bus.out_ready && !bus.flush) |=>
      (out_valid_q && $stable(main_data_q)));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: 8- and 64-bit instances in lockstep against a
// queue model, plus directed stream/backpressure/flush/reset sequences.
module tb_pipe_skid_reg;

  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0123_4567;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;

  int n_vec = 0;
  int n_err = 0;

  pipe_skid_if #(.DATA_W(8))  bus8 ();
  pipe_skid_if #(.DATA_W(64)) bus64 ();

  assign bus8.flush      = flush;
  assign bus8.in_valid   = in_valid;
  assign bus8.in_data    = in_data[7:0];
  assign bus8.out_ready  = out_ready;
  assign bus64.flush     = flush;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_data   = in_data;
  assign bus64.out_ready = out_ready;

  pipe_skid_reg #(.DATA_W(8), .RESET_VAL(RV8)) dut8 (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus8)
  );

  pipe_skid_reg #(.DATA_W(64), .RESET_VAL(RV64)) dut64 (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus64)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Model: the payloads the stage holds, oldest (the one on out_data) first.
  logic [63:0] mq[$];
  bit          shown_reset = 1'b1;

  always @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst || flush) begin
      mq.delete();
      shown_reset = 1'b1;
    end else begin
      bit take_out;
      bit take_in;
      take_out = (mq.size() > 0) && out_ready;
      take_in  = in_valid && (mq.size() < 2);
      if (take_out) void'(mq.pop_front());
      if (take_in) mq.push_back(in_data);
      if (mq.size() > 0) shown_reset = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    bit          live;
    logic [63:0] head;
    live = mq.size() > 0;
    head = live ? mq[0] : RV64;
    check("out_valid8", bus8.out_valid, live);
    check("in_ready8", bus8.in_ready, mq.size() < 2);
    check("count8", bus8.count, 64'(mq.size()));
    check("out_valid64", bus64.out_valid, live);
    check("in_ready64", bus64.in_ready, mq.size() < 2);
    check("count64", bus64.count, 64'(mq.size()));
    if (live || shown_reset) begin
      check("out_data8", bus8.out_data, live ? head[7:0] : RV8);
      check("out_data64", bus64.out_data, head);
    end
  endtask

  always @(negedge cpu_clk) checkOutput();

  task automatic applyStimulus(input bit v, input logic [63:0] d, input bit r, input bit f);
    @(negedge cpu_clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic afterEdge();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic expectLit(input string tag, input bit v, input logic [1:0] c, input bit rdy);
    check({tag, ".out_valid"}, bus8.out_valid, v);
    check({tag, ".count"}, bus8.count, c);
    check({tag, ".in_ready"}, bus8.in_ready, rdy);
    check({tag, ".count64"}, bus64.count, c);
  endtask

  task automatic expectData(input string tag, input logic [7:0] d8, input logic [63:0] d64);
    check({tag, ".data8"}, bus8.out_data, d8);
    check({tag, ".data64"}, bus64.out_data, d64);
  endtask

  initial begin
    #1;
    cpu_rst   = 1'b1;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom};
    out_ready = 1'b1;
    #3;
    expectLit("reset", 1'b0, 2'd0, 1'b1);
    expectData("reset", RV8, RV64);
    @(negedge cpu_clk);
    cpu_rst  = 1'b0;
    in_valid = 1'b0;

    // Streaming at full rate: each payload visible one edge after acceptance.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b1, 1'b0);
      afterEdge();
      expectLit("stream", 1'b1, 2'd1, 1'b1);
      expectData("stream", 8'(i), 64'(i));
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    afterEdge();
    expectLit("stream_end", 1'b0, 2'd0, 1'b1);

    // Backpressure fills the skid and blocks the third payload.
    applyStimulus(1'b1, 64'h11, 1'b1, 1'b0);
    afterEdge();
    expectLit("bp_a", 1'b1, 2'd1, 1'b1);
    expectData("bp_a", 8'h11, 64'h11);
    applyStimulus(1'b1, 64'h22, 1'b0, 1'b0);
    afterEdge();
    expectLit("bp_b", 1'b1, 2'd2, 1'b0);
    expectData("bp_b", 8'h11, 64'h11);
    applyStimulus(1'b1, 64'h33, 1'b0, 1'b0);
    afterEdge();
    expectLit("bp_c", 1'b1, 2'd2, 1'b0);
    expectData("bp_c", 8'h11, 64'h11);

    // Drain while C stays offered.
    applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
    afterEdge();
    expectLit("drain1", 1'b1, 2'd1, 1'b1);
    expectData("drain1", 8'h22, 64'h22);
    applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
    afterEdge();
    expectLit("drain2", 1'b1, 2'd1, 1'b1);
    expectData("drain2", 8'h33, 64'h33);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    afterEdge();
    expectLit("drain3", 1'b0, 2'd0, 1'b1);

    // Flush from full, racing an input and an output transfer.
    applyStimulus(1'b1, 64'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h66, 1'b0, 1'b0);
    afterEdge();
    expectLit("pre_flush", 1'b1, 2'd2, 1'b0);
    applyStimulus(1'b1, 64'h44, 1'b1, 1'b1);
    afterEdge();
    expectLit("flush", 1'b0, 2'd0, 1'b1);
    expectData("flush", RV8, RV64);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    afterEdge();
    expectLit("post_flush", 1'b0, 2'd0, 1'b1);
    expectData("post_flush", RV8, RV64);

    // Asynchronous reset between edges with both entries full.
    applyStimulus(1'b1, 64'h77, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h88, 1'b0, 1'b0);
    afterEdge();
    expectLit("pre_arst", 1'b1, 2'd2, 1'b0);
    #2;
    cpu_rst = 1'b1;
    #1;
    expectLit("arst", 1'b0, 2'd0, 1'b1);
    expectData("arst", RV8, RV64);
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
    afterEdge();
    expectLit("arst_hold", 1'b0, 2'd0, 1'b1);
    @(negedge cpu_clk);
    cpu_rst  = 1'b0;
    in_valid = 1'b0;
    applyStimulus(1'b1, 64'h99, 1'b0, 1'b0);
    afterEdge();
    expectLit("post_arst", 1'b1, 2'd1, 1'b1);
    expectData("post_arst", 8'h99, 64'h99);

    // Random traffic with bursts of stall; the negedge compare does the work.
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit r;
      bit f;
      v = $urandom_range(0, 3) != 0;
      r = (i % 200 < 40) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      f = $urandom_range(0, 60) == 0;
      applyStimulus(v, {$urandom, $urandom}, r, f);
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    @(negedge cpu_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
